// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and ExcCode values.
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE_BIT       = 0;
  localparam int SR_EXL_BIT      = 1;
  localparam int SR_IM_LSB       = 10;
  localparam int CAUSE_EXC_LSB   = 2;
  localparam int CAUSE_IP_LSB    = 10;
  localparam int CAUSE_BD_BIT    = 31;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] pack_sr(sr_t s);
    return {16'b0, s.im, 8'b0, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] pack_cause(cause_t c);
    return {c.bd, 15'b0, c.ip, 3'b0, c.exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 signal bundle. The M stage drives requests and reads back CP0 state;
// there is no handshake: every input is sampled at the posedge, every output is combinational.
interface cp0_unit_if;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] M_pc;
  logic        M_delayed;
  logic [4:0]  M_EXCCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] dout;
  logic [31:0] EPC_out;
  logic [31:0] exc_entry;
  logic        Req;

  modport master (
    output addr, we, din, M_pc, M_delayed, M_EXCCode, HWInt, EXLClr,
    input  dout, EPC_out, exc_entry, Req
  );

  modport slave (
    input  addr, we, din, M_pc, M_delayed, M_EXCCode, HWInt, EXLClr,
    output dout, EPC_out, exc_entry, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 beside the M stage: combines exceptions with hardware interrupts,
// raises Req, records EPC/Cause, and services mfc0/mtc0/eret.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h2023_0007,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic      clk,
  input  logic      reset,
  cp0_unit_if.slave bus
);

  sr_t         sr_q,    sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;

  logic int_req, exc_req, req;

  // Interrupts are masked while EXL is set; they stay pending in Cause.IP meanwhile.
  assign int_req = (|(bus.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign exc_req = (bus.M_EXCCode != EXC_INT) & ~sr_q.exl;
  assign req     = int_req | exc_req;

  always_comb begin
    sr_d     = sr_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    cause_d.ip = bus.HWInt;
    if (req) begin
      sr_d.exl         = 1'b1;
      cause_d.bd       = bus.M_delayed;
      cause_d.exc_code = int_req ? EXC_INT : bus.M_EXCCode;
      epc_d            = bus.M_delayed ? (bus.M_pc - 32'd4) : bus.M_pc;
    end else begin
      if (bus.we && bus.addr == REG_SR) begin
        sr_d.im  = bus.din[SR_IM_LSB +: 6];
        sr_d.exl = bus.din[SR_EXL_BIT];
        sr_d.ie  = bus.din[SR_IE_BIT];
      end
      if (bus.we && bus.addr == REG_EPC) begin
        epc_d = bus.din;
      end
      // eret lands after any same-cycle SR write so the handler always returns with EXL=0.
      if (bus.EXLClr) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    bus.dout = 32'h0;
    case (bus.addr)
      REG_SR:    bus.dout = pack_sr(sr_q);
      REG_CAUSE: bus.dout = pack_cause(cause_q);
      REG_EPC:   bus.dout = epc_q;
      REG_PRID:  bus.dout = PRID;
      default:   bus.dout = 32'h0;
    endcase
  end

  assign bus.EPC_out   = epc_q;
  assign bus.exc_entry = EXC_ENTRY;
  assign bus.Req       = req;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, interrupt/exception entry, priority, EXL masking,
// eret, mtc0/mfc0 ordering and read-only registers.
module tb_cp0_unit;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Step past the next posedge; inputs are changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.dout;
  endtask

  task automatic idle_inputs();
    bus.we        = 1'b0;
    bus.addr      = 5'd0;
    bus.din       = 32'h0;
    bus.M_pc      = 32'h0;
    bus.M_delayed = 1'b0;
    bus.M_EXCCode = 5'd0;
    bus.HWInt     = 6'd0;
    bus.EXLClr    = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic eret();
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    read_reg(5'd12, v); check("reset_sr", v, 32'h0);
    read_reg(5'd13, v); check("reset_cause", v, 32'h0);
    read_reg(5'd14, v); check("reset_epc", v, 32'h0);
    read_reg(5'd15, v); check("prid", v, 32'h2023_0007);
    read_reg(5'd3,  v); check("unmapped_read", v, 32'h0);
    check("reset_req", {31'b0, bus.Req}, 32'h0);
    check("exc_entry", bus.exc_entry, 32'h0000_4180);
    tick();
    reset = 1'b1;
    tick();

    // Enable all interrupt lines with IE=1.
    mtc0(5'd12, 32'h0000_fc01);
    read_reg(5'd12, v); check("sr_write", v, 32'h0000_fc01);

    // Hardware interrupt on line 2 (Cause bit 12).
    bus.HWInt = 6'b000100;
    bus.M_pc  = 32'h0000_3010;
    #1;
    check("int_req_high", {31'b0, bus.Req}, 32'h1);
    tick();
    read_reg(5'd14, v); check("int_epc", v, 32'h0000_3010);
    check("int_epc_out", bus.EPC_out, 32'h0000_3010);
    read_reg(5'd13, v); check("int_cause", v, 32'h0000_1000);
    read_reg(5'd12, v); check("int_sr_exl", v, 32'h0000_fc03);
    check("int_req_drops", {31'b0, bus.Req}, 32'h0);

    // EXL masks an exception; state must hold.
    bus.M_EXCCode = 5'd4;
    bus.M_pc      = 32'h0000_3050;
    #1;
    check("exl_masks_exc", {31'b0, bus.Req}, 32'h0);
    tick();
    read_reg(5'd14, v); check("exl_epc_hold", v, 32'h0000_3010);
    read_reg(5'd13, v); check("exl_cause_hold", v, 32'h0000_1000);
    bus.M_EXCCode = 5'd0;

    // eret with the interrupt still pending: it fires right after EXL clears.
    eret();
    read_reg(5'd12, v); check("eret_sr", v, 32'h0000_fc01);
    check("pending_int_fires", {31'b0, bus.Req}, 32'h1);
    bus.HWInt = 6'd0;
    #1;
    check("pending_int_gone", {31'b0, bus.Req}, 32'h0);
    tick();

    // Overflow in a delay slot.
    bus.M_EXCCode = 5'd12;
    bus.M_delayed = 1'b1;
    bus.M_pc      = 32'h0000_3024;
    #1;
    check("ov_req", {31'b0, bus.Req}, 32'h1);
    tick();
    read_reg(5'd14, v); check("ov_epc", v, 32'h0000_3020);
    read_reg(5'd13, v); check("ov_cause", v, 32'h8000_0030);
    bus.M_EXCCode = 5'd0;
    bus.M_delayed = 1'b0;
    eret();

    // Interrupt beats a same-cycle RI exception.
    bus.HWInt     = 6'b000001;
    bus.M_EXCCode = 5'd10;
    bus.M_pc      = 32'h0000_3100;
    tick();
    read_reg(5'd13, v); check("prio_cause", v, 32'h0000_0400);
    read_reg(5'd14, v); check("prio_epc", v, 32'h0000_3100);
    bus.HWInt     = 6'd0;
    bus.M_EXCCode = 5'd0;
    eret();

    // mtc0 to EPC in a faulting cycle is dropped.
    bus.M_EXCCode = 5'd8;
    bus.M_pc      = 32'h0000_3200;
    mtc0(5'd14, 32'h0000_4000);
    read_reg(5'd14, v); check("drop_mtc0_epc", v, 32'h0000_3200);
    read_reg(5'd13, v); check("syscall_cause", v, 32'h0000_0020);
    bus.M_EXCCode = 5'd0;
    eret();

    mtc0(5'd14, 32'h0000_4000);
    read_reg(5'd14, v); check("mtc0_epc", v, 32'h0000_4000);
    mtc0(5'd13, 32'hffff_ffff);
    read_reg(5'd13, v); check("cause_read_only", v, 32'h0000_0020);
    mtc0(5'd15, 32'h0);
    read_reg(5'd15, v); check("prid_read_only", v, 32'h2023_0007);

    // mfc0 in the same cycle as mtc0 sees the old value.
    bus.we   = 1'b1;
    bus.addr = 5'd14;
    bus.din  = 32'h5555_aaaa;
    #1;
    check("mfc0_old_value", bus.dout, 32'h0000_4000);
    tick();
    bus.we = 1'b0;
    read_reg(5'd14, v); check("mtc0_new_value", v, 32'h5555_aaaa);

    // SR write and eret together: written fields kept, EXL forced to 0.
    bus.EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_fc03);
    bus.EXLClr = 1'b0;
    read_reg(5'd12, v); check("mtc0_sr_with_eret", v, 32'h0000_fc01);

    // Delay-slot EPC wraps below zero.
    bus.M_EXCCode = 5'd5;
    bus.M_delayed = 1'b1;
    bus.M_pc      = 32'h0000_0002;
    tick();
    read_reg(5'd14, v); check("epc_wrap", v, 32'hffff_fffe);
    read_reg(5'd13, v); check("ades_cause", v, 32'h8000_0014);
    bus.M_EXCCode = 5'd0;
    bus.M_delayed = 1'b0;
    bus.HWInt     = 6'b000001;

    // Asynchronous reset between clock edges.
    #1;
    reset = 1'b0;
    #1;
    read_reg(5'd12, v); check("async_rst_sr", v, 32'h0);
    read_reg(5'd13, v); check("async_rst_cause", v, 32'h0);
    read_reg(5'd14, v); check("async_rst_epc", v, 32'h0);
    check("async_rst_req", {31'b0, bus.Req}, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
